mpmc9_ch_arbiter: RTL and testbench
===================================

MPMC9_CH_ARBITER -- requirements
Module: mpmc9_ch_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: max consecutive grants to one channel while others request (legal 1..15).
REQ-002 SHALL have parameter PRI_CH0, default 1: 1 = channel 0 fixed highest priority; 0 = channel 0 round-robin like the others.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port state  input  4  controller state (mpmc9_pkg encoding); IDLE = controller ready to latch channel data.
REQ-006 SHALL have port req  input  8  per-channel request pending, bit n = channel n.
REQ-007 SHALL have port done  input  1  single-cycle pulse: granted transaction complete.
REQ-008 SHALL have port ch  output  4  registered selected channel, consumed by the write-data select stage; 4'hF = none.
REQ-009 SHALL have port grant  output  8  registered one-hot grant, zero when ch==4'hF.
REQ-010 SHALL have port ch_valid  output  1  registered; high when ch holds a live grant.

Function
REQ-011 SHALL implement FSM ARB_SEARCH, ARB_GRANTED, ARB_BUSY.
REQ-012 ARB_SEARCH: req!=0 -> register winner on ch/grant, ch_valid=1, go ARB_GRANTED; req==0 -> stay, ch=4'hF, grant=0, ch_valid=0.
REQ-013 Latency SHALL be one cycle: req seen in ARB_SEARCH at edge n -> ch/grant/ch_valid valid after edge n+1.
REQ-014 ARB_GRANTED: ch, grant SHALL stay constant; state leaves IDLE -> ARB_BUSY.
REQ-015 ARB_GRANTED with state==IDLE and granted req bit low -> withdraw: ch=4'hF, grant=0, ch_valid=0, return ARB_SEARCH; burst counter and last-winner pointer unchanged.
REQ-016 ARB_BUSY: ch, grant held; req changes ignored; done=1 -> ch_valid=0, ch=4'hF, grant=0, go ARB_SEARCH.
REQ-017 done outside ARB_BUSY SHALL be ignored; done and state leaving IDLE in the same ARB_GRANTED cycle -> ARB_BUSY only.
REQ-018 Winner: PRI_CH0=1 and req[0] -> channel 0, overriding burst and rotation.
REQ-019 Otherwise, last winner L still requesting and burst_cnt < MAX_BURST-1 -> L wins again, burst_cnt++.
REQ-020 Otherwise round-robin: first requesting channel scanning L+1, L+2, ... mod 8 (wrap 7->0), including L last.
REQ-021 burst_cnt SHALL be 4 bits; reset to 0 when winner != L; never exceed MAX_BURST-1; MAX_BURST=1 -> pure round-robin.
REQ-022 Last-winner pointer L and burst_cnt SHALL update only on entry to ARB_BUSY (grant accepted), not on grant issue.
REQ-023 Only requester -> wins every time regardless of burst_cnt (burst limit applies only vs. competitors; burst_cnt saturates).
REQ-024 grant SHALL always equal the one-hot decode of ch when ch_valid=1.

Reset
REQ-025 rst SHALL force ARB_SEARCH, ch=4'hF, grant=0, ch_valid=0, burst_cnt=0, L=7 (so channel 0 is first in rotation).
REQ-026 rst in any state, including mid-ARB_BUSY, SHALL take priority over done/req; next cycle after deassert is ARB_SEARCH.

Structure
REQ-027 arb_state_t enum and NO_CH constant (4'hF) SHALL live in mpmc9_pkg alongside the controller state encoding; IDLE reused from it.
REQ-028 Round-robin priority search (req, L -> winner, any) SHALL be one combinational sub-module mpmc9_rr_pick.
REQ-029 Outputs SHALL be registered; no combinational path req->ch.

Verification
REQ-030 Reset then req=8'h00 for 10 cycles -> ch=4'hF, grant=0, ch_valid=0 throughout.
REQ-031 PRI_CH0=0, req=8'hFF held, each grant accepted then done -> grant order 0,0,0,0,1,1,1,1,2,... (MAX_BURST=4), wraps 7->0.
REQ-032 PRI_CH0=1, channel 3 granted in ARB_BUSY, req[0] rises -> ch stays 3 until done; next grant ch=0.
REQ-033 ch=5 in ARB_GRANTED, state==IDLE, req[5] drops -> next cycle ch=4'hF, ch_valid=0; then req=8'h40 -> ch=6, burst_cnt unchanged.
REQ-034 rst asserted in ARB_BUSY with done=1 same cycle -> ch=4'hF, ch_valid=0, L=7; req=8'h81 with PRI_CH0=0 -> ch=0.
REQ-035 Only req[2]=1, 10 accepted transactions -> ch=2 every time, burst_cnt never exceeds 3.

Source files
------------

// File: rtl/mpmc9_pkg.sv
// rtl/mpmc9_pkg.sv - controller state encoding and channel arbiter types
package mpmc9_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'h0,
    ACTIVATE  = 4'h1,
    READ_CMD  = 4'h2,
    WRITE_CMD = 4'h3,
    PRECHARGE = 4'h4,
    REFRESH   = 4'h5
  } mpmc9_state_t;

  typedef enum logic [1:0] {
    ARB_SEARCH  = 2'd0,
    ARB_GRANTED = 2'd1,
    ARB_BUSY    = 2'd2
  } arb_state_t;

  localparam logic [3:0] NO_CH = 4'hF;

  function automatic logic [7:0] ch_onehot(input logic [2:0] idx);
    logic [7:0] r;
    r = 8'h00;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mpmc9_rr_pick.sv
// rtl/mpmc9_rr_pick.sv - round-robin search starting after the last winner
module mpmc9_rr_pick (
  input  logic [7:0] req,
  input  logic [2:0] last,
  output logic [2:0] winner,
  output logic       any
);

  logic [2:0] idx;

  // Scan last+1 .. last+8 (mod 8) so the last winner is considered last.
  always_comb begin
    winner = last;
    any    = 1'b0;
    idx    = last;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!any && req[idx]) begin
        winner = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpmc9_ch_arbiter.sv
// rtl/mpmc9_ch_arbiter.sv - 8-channel arbiter with burst limit and optional fixed-priority channel 0
module mpmc9_ch_arbiter
  import mpmc9_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter bit PRI_CH0   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic [7:0] req,
  input  logic       done,
  output logic [3:0] ch,
  output logic [7:0] grant,
  output logic       ch_valid
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

  arb_state_t arb_q, arb_d;
  logic [3:0] ch_q, ch_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic [2:0] last_q, last_d;
  logic [3:0] burst_q, burst_d;
  // No burst history exists until the first accepted grant after reset.
  logic       lvalid_q, lvalid_d;

  logic [2:0] rr_win;
  logic       rr_any;
  logic [2:0] win;

  mpmc9_rr_pick u_pick (
    .req    (req),
    .last   (last_q),
    .winner (rr_win),
    .any    (rr_any)
  );

  always_comb begin
    if (PRI_CH0 && req[0])
      win = 3'd0;
    else if (lvalid_q && req[last_q] && (burst_q < BURST_LIM))
      win = last_q;
    else
      win = rr_win;
  end

  always_comb begin
    arb_d    = arb_q;
    ch_d     = ch_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    last_d   = last_q;
    burst_d  = burst_q;
    lvalid_d = lvalid_q;
    case (arb_q)
      ARB_SEARCH: begin
        if (rr_any) begin
          ch_d    = {1'b0, win};
          grant_d = ch_onehot(win);
          valid_d = 1'b1;
          arb_d   = ARB_GRANTED;
        end else begin
          ch_d    = NO_CH;
          grant_d = 8'h00;
          valid_d = 1'b0;
        end
      end
      ARB_GRANTED: begin
        if (state != IDLE) begin
          arb_d    = ARB_BUSY;
          last_d   = ch_q[2:0];
          lvalid_d = 1'b1;
          if (lvalid_q && ch_q[2:0] == last_q)
            burst_d = (burst_q < BURST_LIM) ? burst_q + 4'd1 : burst_q;
          else
            burst_d = 4'd0;
        end else if (!req[ch_q[2:0]]) begin
          ch_d    = NO_CH;
          grant_d = 8'h00;
          valid_d = 1'b0;
          arb_d   = ARB_SEARCH;
        end
      end
      ARB_BUSY: begin
        if (done) begin
          ch_d    = NO_CH;
          grant_d = 8'h00;
          valid_d = 1'b0;
          arb_d   = ARB_SEARCH;
        end
      end
      default: begin
        ch_d    = NO_CH;
        grant_d = 8'h00;
        valid_d = 1'b0;
        arb_d   = ARB_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arb_q    <= ARB_SEARCH;
      ch_q     <= NO_CH;
      grant_q  <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 3'd7;
      burst_q  <= 4'd0;
      lvalid_q <= 1'b0;
    end else begin
      arb_q    <= arb_d;
      ch_q     <= ch_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      lvalid_q <= lvalid_d;
    end
  end

  assign ch       = ch_q;
  assign grant    = grant_q;
  assign ch_valid = valid_q;

endmodule

// File: tb/tb_mpmc9_ch_arbiter.sv
// tb/tb_mpmc9_ch_arbiter.sv - directed bench for the channel arbiter
module tb_mpmc9_ch_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state;
  logic [7:0] req;
  logic       done;
  logic [3:0] ch_a, ch_b;
  logic [7:0] grant_a, grant_b;
  logic       valid_a, valid_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // u_rr: channel 0 rotates with the others; u_pri: channel 0 fixed highest priority
  mpmc9_ch_arbiter #(.MAX_BURST(4), .PRI_CH0(1'b0)) u_rr (
    .clk(clk), .rst(rst), .state(state), .req(req), .done(done),
    .ch(ch_a), .grant(grant_a), .ch_valid(valid_a)
  );

  mpmc9_ch_arbiter #(.MAX_BURST(4), .PRI_CH0(1'b1)) u_pri (
    .clk(clk), .rst(rst), .state(state), .req(req), .done(done),
    .ch(ch_b), .grant(grant_b), .ch_valid(valid_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 8'h00;
    done  = 1'b0;
    state = 4'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for a grant on the selected instance, check it, accept it, complete it.
  task automatic txn(input bit sel, input logic [3:0] exp, input string tag);
    int n;
    logic [3:0] cur;
    logic [7:0] oh;
    n = 0;
    while (!(sel ? valid_b : valid_a) && n < 8) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(sel ? valid_b : valid_a), 32'd1);
    cur = sel ? ch_b : ch_a;
    check({tag, "_ch"}, 32'(cur), 32'(exp));
    oh = 8'h00;
    oh[exp[2:0]] = 1'b1;
    check({tag, "_grant"}, 32'(sel ? grant_b : grant_a), 32'(oh));
    state = 4'h1;
    tick();
    done = 1'b1;
    tick();
    done  = 1'b0;
    state = 4'h0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] e;

    // Idle: no requests, no grants on either instance.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      check("idle_a", {ch_a, grant_a, 3'b0, valid_a}, {4'hF, 8'h00, 4'h0});
      check("idle_b", {ch_b, grant_b, 3'b0, valid_b}, {4'hF, 8'h00, 4'h0});
      tick();
    end

    // All requesting, rotating channel 0: four grants per channel, wrapping 7 -> 0.
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 36; k++) begin
      e = 4'((k / 4) % 8);
      txn(1'b0, e, $sformatf("burst%0d", k));
    end

    // Fixed priority: req[0] rising while channel 3 is busy does not preempt.
    do_reset();
    req = 8'h08;
    tick();
    check("pri_first_ch", 32'(ch_b), 32'd3);
    state = 4'h1;
    tick();
    state = 4'h0;
    req = 8'h09;
    for (int i = 0; i < 3; i++) begin
      check("pri_hold_ch", 32'(ch_b), 32'd3);
      check("pri_hold_grant", 32'(grant_b), 32'h08);
      tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    check("pri_done_valid", 32'(valid_b), 32'd0);
    check("pri_done_ch", 32'(ch_b), 32'hF);
    tick();
    check("pri_next_ch", 32'(ch_b), 32'd0);
    check("pri_next_grant", 32'(grant_b), 32'h01);

    // Withdraw: ch 5 granted while controller still IDLE, request drops.
    do_reset();
    req = 8'h20;
    tick();
    check("wd_ch5", 32'(ch_a), 32'd5);
    req = 8'h00;
    tick();
    check("wd_ch_none", 32'(ch_a), 32'hF);
    check("wd_valid", 32'(valid_a), 32'd0);
    check("wd_grant", 32'(grant_a), 32'h00);
    req = 8'h40;
    tick();
    check("wd_ch6", 32'(ch_a), 32'd6);
    check("wd_grant6", 32'(grant_a), 32'h40);
    txn(1'b0, 4'd6, "wd_accept6");

    // Reset wins over done mid-busy, and restores the rotation pointer.
    do_reset();
    req = 8'h04;
    tick();
    state = 4'h1;
    tick();
    check("rst_busy_ch", 32'(ch_a), 32'd2);
    rst  = 1'b1;
    done = 1'b1;
    tick();
    rst   = 1'b0;
    done  = 1'b0;
    state = 4'h0;
    check("rst_ch", 32'(ch_a), 32'hF);
    check("rst_valid", 32'(valid_a), 32'd0);
    req = 8'h81;
    tick();
    check("rst_next_ch", 32'(ch_a), 32'd0);

    // Lone requester keeps winning; burst counter saturates instead of blocking it.
    do_reset();
    req = 8'h04;
    for (int k = 0; k < 10; k++)
      txn(1'b0, 4'd2, $sformatf("solo%0d", k));
    req = 8'h0C;
    txn(1'b0, 4'd3, "solo_then_rr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
